// File: rtl/pack_pkg.sv
// Shared constants and helpers for the pixel stream packer.
package pack_pkg;

  localparam int PACK_ALIGNED = 0;
  localparam int PACK_DENSE   = 1;

  // Fill counter width; holds up to PACK_BIT+PIXEL_BIT = 1023.
  localparam int FILL_W = 10;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_FLUSH2} pack_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int pack_div(input int pix, input int pack);
    return pack / pix;
  endfunction

endpackage

// File: rtl/pack_out_reg.sv
// One-entry output slot: holds a packed word and its tags until downstream takes it.
module pack_out_reg #(
  parameter int DATA_W = 64,
  parameter int X_W    = 11,
  parameter int Y_W    = 11
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  input  logic              sof_i,
  input  logic              eol_i,
  output logic              valid_o,
  output logic              slot_free_o,
  output logic [DATA_W-1:0] data_o,
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o,
  output logic              sof_o,
  output logic              eol_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              sof_q, eol_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      x_q     <= x_i;
      y_q     <= y_i;
      sof_q   <= sof_i;
      eol_q   <= eol_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign slot_free_o = ~valid_q | ready_i;
  assign data_o      = data_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign sof_o       = sof_q;
  assign eol_o       = eol_q;

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs one pixel per beat into wide words, aligned or bit-dense, with eol flush and x/y tags.
module pixel_stream_packer
  import pack_pkg::*;
#(
  parameter int PIXEL_BIT = 15,
  parameter int PACK_BIT  = 64,
  parameter int DENSE     = 0,
  parameter int X_WIDTH   = 11,
  parameter int Y_WIDTH   = 11
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PIXEL_BIT-1:0] i_data,
  input  logic                 i_sof,
  input  logic                 i_eol,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PACK_BIT-1:0]  o_data,
  output logic [X_WIDTH-1:0]   o_x,
  output logic [Y_WIDTH-1:0]   o_y,
  output logic                 o_sof,
  output logic                 o_eol,
  output logic                 o_sof_err
);

  localparam int ACC_W     = PACK_BIT + PIXEL_BIT;
  localparam int DIV       = pack_div(PIXEL_BIT, PACK_BIT);
  localparam int WORD_FILL = (DENSE == PACK_DENSE) ? PACK_BIT : DIV * PIXEL_BIT;
  localparam logic [FILL_W-1:0] WORD_FILL_F = FILL_W'(WORD_FILL);
  localparam logic [FILL_W-1:0] PIX_F       = FILL_W'(PIXEL_BIT);

  if (PIXEL_BIT > PACK_BIT || PIXEL_BIT < 1) begin : g_bad_pixel
    $error("pixel_stream_packer: PIXEL_BIT must be 1..PACK_BIT");
  end
  if (clog2(ACC_W + 1) > FILL_W) begin : g_bad_fill
    $error("pixel_stream_packer: accumulator too wide for fill counter");
  end
  if (DENSE != PACK_ALIGNED && DENSE != PACK_DENSE) begin : g_bad_mode
    $error("pixel_stream_packer: DENSE must be 0 or 1");
  end

  pack_state_e          state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 sof_pend_q, sof_pend_d;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic                 rdy_q, sof_err_q;

  logic                 slot_free, accept, sof_acc, full;
  logic [ACC_W-1:0]     base_acc, ins;
  logic [FILL_W-1:0]    base_fill, new_fill, res_fill;
  logic                 ld, ld_sof, ld_eol;
  logic [PACK_BIT-1:0]  ld_data;
  logic [X_WIDTH-1:0]   ld_x;
  logic [Y_WIDTH-1:0]   ld_y;

  // Ready never looks at i_valid; it only depends on state and the output slot.
  assign o_ready   = rdy_q & (state_q != ST_FLUSH2) & slot_free;
  assign accept    = i_valid & o_ready;
  assign sof_acc   = accept & i_sof;
  assign base_fill = sof_acc ? '0 : fill_q;
  assign base_acc  = sof_acc ? '0 : acc_q;
  assign ins       = base_acc | (ACC_W'(i_data) << base_fill);
  assign new_fill  = base_fill + PIX_F;
  assign full      = new_fill >= WORD_FILL_F;
  assign res_fill  = new_fill - WORD_FILL_F;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    sof_pend_d = sof_pend_q;
    x_d        = x_q;
    y_d        = y_q;
    ld         = 1'b0;
    ld_data    = ins[PACK_BIT-1:0];
    ld_x       = sof_acc ? '0 : x_q;
    ld_y       = sof_acc ? '0 : y_q;
    ld_sof     = sof_acc | sof_pend_q;
    ld_eol     = 1'b0;
    if (state_q == ST_FLUSH2) begin
      if (slot_free) begin
        ld      = 1'b1;
        ld_data = acc_q[PACK_BIT-1:0];
        ld_sof  = 1'b0;
        ld_eol  = 1'b1;
        acc_d   = '0;
        fill_d  = '0;
        x_d     = '0;
        y_d     = y_q + 1'b1;
        state_d = ST_IDLE;
      end
    end else if (accept) begin
      x_d = ld_x;
      y_d = ld_y;
      if (full) begin
        ld         = 1'b1;
        acc_d      = ins >> WORD_FILL;
        fill_d     = res_fill;
        sof_pend_d = 1'b0;
        x_d        = ld_x + 1'b1;
        if (i_eol && res_fill == '0) begin
          ld_eol = 1'b1;
          x_d    = '0;
          y_d    = ld_y + 1'b1;
        end
      end else if (i_eol) begin
        ld         = 1'b1;
        ld_eol     = 1'b1;
        acc_d      = '0;
        fill_d     = '0;
        sof_pend_d = 1'b0;
        x_d        = '0;
        y_d        = ld_y + 1'b1;
      end else begin
        acc_d      = ins;
        fill_d     = new_fill;
        sof_pend_d = sof_acc | sof_pend_q;
      end
      // A dense straddle at eol leaves a residual that needs its own word next cycle.
      if (full && i_eol && res_fill != '0) state_d = ST_FLUSH2;
      else state_d = (fill_d == '0) ? ST_IDLE : ST_ACC;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      fill_q     <= '0;
      sof_pend_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rdy_q      <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      sof_pend_q <= sof_pend_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rdy_q      <= 1'b1;
      sof_err_q  <= sof_acc & (fill_q != '0);
    end
  end

  assign o_sof_err = sof_err_q;

  pack_out_reg #(.DATA_W(PACK_BIT), .X_W(X_WIDTH), .Y_W(Y_WIDTH)) u_out (
    .clk_i       (i_clk),
    .arst_i      (i_arst),
    .load_i      (ld),
    .ready_i     (i_ready),
    .data_i      (ld_data),
    .x_i         (ld_x),
    .y_i         (ld_y),
    .sof_i       (ld_sof),
    .eol_i       (ld_eol),
    .valid_o     (o_valid),
    .slot_free_o (slot_free),
    .data_o      (o_data),
    .x_o         (o_x),
    .y_o         (o_y),
    .sof_o       (o_sof),
    .eol_o       (o_eol)
  );

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench: an aligned 15->64 packer (X_WIDTH=2) and a dense 10->64 packer.
module tb_pixel_stream_packer;

  typedef struct { logic [63:0] d; int x; int y; bit sof; bit eol; } wrd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv_a = 1'b0, sof_a = 1'b0, eol_a = 1'b0, ir_a = 1'b1;
  logic [14:0] id_a = '0;
  logic        or_a, ov_a, os_a, oe_a, oerr_a;
  logic [63:0] od_a;
  logic [1:0]  ox_a;
  logic [10:0] oy_a;

  logic        iv_d = 1'b0, sof_d = 1'b0, eol_d = 1'b0, ir_d = 1'b1;
  logic [9:0]  id_d = '0;
  logic        or_d, ov_d, os_d, oe_d, oerr_d;
  logic [63:0] od_d;
  logic [10:0] ox_d, oy_d;

  pixel_stream_packer #(.PIXEL_BIT(15), .PACK_BIT(64), .DENSE(0), .X_WIDTH(2), .Y_WIDTH(11)) u_al (
    .i_clk(clk), .i_arst(rst), .i_valid(iv_a), .o_ready(or_a), .i_data(id_a), .i_sof(sof_a),
    .i_eol(eol_a), .o_valid(ov_a), .i_ready(ir_a), .o_data(od_a), .o_x(ox_a), .o_y(oy_a),
    .o_sof(os_a), .o_eol(oe_a), .o_sof_err(oerr_a));

  pixel_stream_packer #(.PIXEL_BIT(10), .PACK_BIT(64), .DENSE(1), .X_WIDTH(11), .Y_WIDTH(11)) u_dn (
    .i_clk(clk), .i_arst(rst), .i_valid(iv_d), .o_ready(or_d), .i_data(id_d), .i_sof(sof_d),
    .i_eol(eol_d), .o_valid(ov_d), .i_ready(ir_d), .o_data(od_d), .o_x(ox_d), .o_y(oy_d),
    .o_sof(os_d), .o_eol(oe_d), .o_sof_err(oerr_d));

  int   vectors = 0, miscompares = 0;
  wrd_t qa[$], qd[$];
  bit   ba[$], bd[$];
  int   mxa = 0, mya = 0, mxd = 0, myd = 0;
  bit   sofpa = 0, sofpd = 0;
  int   err_seen_a = 0, errexp_a = 0, low_d = 0;
  bit   acc_a, acc_d, rnd_rdy = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic emit_a(input bit e);
    wrd_t w;
    int n;
    w.d = '0;
    n = ba.size();
    for (int i = 0; i < n; i++) w.d[i] = ba.pop_front();
    w.x = mxa; w.y = mya; w.sof = sofpa; w.eol = e;
    sofpa = 0;
    qa.push_back(w);
    if (e) begin mxa = 0; mya = (mya + 1) % 2048; end
    else mxa = (mxa + 1) % 4;
  endtask

  task automatic model_a(input logic [14:0] p, input bit s, input bit e);
    if (s) begin
      if (ba.size() != 0) errexp_a++;
      ba.delete(); mxa = 0; mya = 0; sofpa = 1;
    end
    for (int i = 0; i < 15; i++) ba.push_back(p[i]);
    if (ba.size() == 60 || e) emit_a(e);
  endtask

  task automatic model_d(input logic [9:0] p, input bit s, input bit e);
    wrd_t w;
    int n;
    if (s) begin bd.delete(); mxd = 0; myd = 0; sofpd = 1; end
    for (int i = 0; i < 10; i++) bd.push_back(p[i]);
    if (bd.size() >= 64) begin
      for (int i = 0; i < 64; i++) w.d[i] = bd.pop_front();
      w.x = mxd; w.y = myd; w.sof = sofpd; w.eol = 0;
      sofpd = 0; mxd = (mxd + 1) % 2048;
      qd.push_back(w);
    end
    if (e) begin
      if (bd.size() > 0) begin
        w.d = '0;
        n = bd.size();
        for (int i = 0; i < n; i++) w.d[i] = bd.pop_front();
        w.x = mxd; w.y = myd; w.sof = sofpd; w.eol = 1;
        sofpd = 0;
        qd.push_back(w);
      end else begin
        w = qd.pop_back(); w.eol = 1; qd.push_back(w);
      end
      mxd = 0; myd = (myd + 1) % 2048;
    end
  endtask

  task automatic clr_models();
    ba.delete(); bd.delete(); qa.delete(); qd.delete();
    mxa = 0; mya = 0; mxd = 0; myd = 0; sofpa = 0; sofpd = 0;
  endtask

  task automatic mon();
    wrd_t w;
    if (oerr_a) err_seen_a++;
    if (!or_d) low_d++;
    if (ov_a && ir_a) begin
      vectors++;
      assert (qa.size() != 0) else begin
        miscompares++;
        $error("FAIL a_word: observed extra word %h expected none", od_a);
      end
      if (qa.size() != 0) begin
        w = qa.pop_front();
        chk("a_word", 128'({od_a, 11'(ox_a), oy_a, os_a, oe_a}),
            128'({w.d, 11'(w.x), 11'(w.y), w.sof, w.eol}));
      end
    end
    if (ov_d && ir_d) begin
      vectors++;
      assert (qd.size() != 0) else begin
        miscompares++;
        $error("FAIL d_word: observed extra word %h expected none", od_d);
      end
      if (qd.size() != 0) begin
        w = qd.pop_front();
        chk("d_word", 128'({od_d, ox_d, oy_d, os_d, oe_d}),
            128'({w.d, 11'(w.x), 11'(w.y), w.sof, w.eol}));
      end
    end
    acc_a = iv_a & or_a;
    acc_d = iv_d & or_d;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      ir_a = ($urandom_range(0, 3) != 0);
      ir_d = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic px_a(input logic [14:0] p, input bit s, input bit e);
    bit done;
    done = 0;
    iv_a = 1; id_a = p; sof_a = s; eol_a = e;
    for (int i = 0; i < 200 && !done; i++) begin cyc(); done = acc_a; end
    iv_a = 0; sof_a = 0; eol_a = 0;
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL a_accept: observed no accept expected accept of %h", p);
    end
    if (done) model_a(p, s, e);
  endtask

  task automatic px_d(input logic [9:0] p, input bit s, input bit e);
    bit done;
    done = 0;
    iv_d = 1; id_d = p; sof_d = s; eol_d = e;
    for (int i = 0; i < 200 && !done; i++) begin cyc(); done = acc_d; end
    iv_d = 0; sof_d = 0; eol_d = 0;
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL d_accept: observed no accept expected accept of %h", p);
    end
    if (done) model_d(p, s, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (qa.size() != 0 || qd.size() != 0); i++) cyc();
    cyc();
    chk("a_drain", 128'(qa.size()), 128'(0));
    chk("d_drain", 128'(qd.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    cyc(); cyc();
    chk("a_reset", 128'({ov_a, or_a, od_a, ox_a, oy_a, os_a, oe_a, oerr_a}), 128'(0));
    chk("d_reset", 128'({ov_d, or_d, od_d, ox_d, oy_d, os_d, oe_d, oerr_d}), 128'(0));
    rst = 0;
    cyc();
    chk("a_ready_after_rst", 128'(or_a), 128'(1));
    chk("d_ready_after_rst", 128'(or_d), 128'(1));

    // aligned line of 8 pixels
    for (int i = 1; i <= 8; i++) px_a(15'(i), 0, i == 8);
    drain();

    // dense straddle at eol: full word then residual, one stall cycle
    low_d = 0;
    for (int i = 0; i < 7; i++) px_d(10'h3FF, 0, i == 6);
    drain();
    chk("d_flush_ready_low", 128'(low_d), 128'(1));

    // dense exact fill at eol: 320 bits, no extra word
    for (int i = 0; i < 32; i++) px_d(10'($urandom), 0, i == 31);
    drain();

    // single-pixel line with sof and eol together
    px_a(15'h1234, 1, 1);
    drain();

    // backpressure hold
    ir_a = 0;
    for (int i = 0; i < 4; i++) px_a(15'($urandom), 0, 0);
    iv_a = 1; id_a = 15'h7ABC;
    repeat (10) begin
      cyc();
      chk("bp_ready_low", 128'(or_a), 128'(0));
      chk("bp_hold", 128'({ov_a, od_a, ox_a}), 128'({1'b1, qa[0].d, 2'(qa[0].x)}));
    end
    ir_a = 1;
    px_a(15'h7ABC, 0, 0);
    for (int i = 0; i < 3; i++) px_a(15'($urandom), 0, i == 2);
    drain();

    // sof with a partial word pending
    err_seen_a = 0; errexp_a = 0;
    px_a(15'h0AAA, 0, 0);
    px_a(15'h0BBB, 0, 0);
    px_a(15'h0CCC, 1, 0);
    for (int i = 0; i < 3; i++) px_a(15'($urandom), 0, i == 2);
    drain();
    chk("sof_err_count", 128'(err_seen_a), 128'(errexp_a));

    // three 24-pixel lines with random downstream stalls, then a new frame
    rnd_rdy = 1;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 24; i++) px_a(15'($urandom), l == 0 && i == 0, i == 23);
    for (int i = 0; i < 4; i++) px_a(15'($urandom), i == 0, i == 3);
    rnd_rdy = 0; ir_a = 1; ir_d = 1;
    drain();

    // asynchronous reset with partial state in both packers
    ir_d = 0;
    for (int i = 0; i < 7; i++) px_d(10'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) px_a(15'($urandom), 0, 0);
    rst = 1;
    #1;
    chk("a_arst", 128'({ov_a, or_a, od_a, ox_a, oy_a, os_a, oe_a, oerr_a}), 128'(0));
    chk("d_arst", 128'({ov_d, or_d, od_d, ox_d, oy_d, os_d, oe_d, oerr_d}), 128'(0));
    clr_models();
    cyc(); cyc();
    rst = 0; ir_d = 1;
    cyc();
    for (int i = 0; i < 4; i++) px_a(15'h0100 + 15'(i), 0, i == 3);
    for (int i = 0; i < 3; i++) px_d(10'h011 + 10'(i), 0, i == 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
